ps2_kbd_tx: RTL and testbench
=============================

Name: ps2_kbd_tx

Overview:
- PS/2 device-side (keyboard-end) frame transmitter: turns queued scan-code bytes into PS/2 serial frames on ps2_clk/ps2_data.
- Drives the input pins of the existing PS/2 keyboard receiver in simulation and on-board loopback, so the keyboard FSM/decode path can be exercised without a physical keyboard.
- Contains an 8-bit write FIFO, a half-period clock divider and a frame FSM with host-inhibit abort/retry.

Parameters:
- CLK_DIV, 4, system clk cycles per PS/2 half-period (>=2)
- GAP_CYCLES, 8, idle cycles (ps2_clk and ps2_data high) after each stop bit (>=1)
- FIFO_DEPTH, 8, FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock, all state on rising edge
- clrn  in  1  asynchronous, active-high reset
- wr_en  in  1  push wr_data into FIFO this cycle
- wr_data  in  8  scan-code byte to send
- inhibit  in  1  host holds PS/2 clock low; blocks/aborts transmission
- full  out  1  FIFO full (registered count == FIFO_DEPTH)
- overflow  out  1  1-cycle pulse: wr_en dropped because full
- busy  out  1  FSM not in IDLE
- ps2_clk  out  1  PS/2 clock to receiver, idles high
- ps2_data  out  1  PS/2 data to receiver, idles high

Behaviour:
- Reset (async, while clrn=1): ps2_clk=1, ps2_data=1, full=0, overflow=0, busy=0; FIFO emptied; FSM=IDLE; counters=0. Applies immediately mid-frame; a partial frame is never completed.
- Frame: 11 bits, LSB-first order: start(0), d0..d7, parity (odd: ~^data), stop(1).
- FIFO: write accepted when wr_en=1 and full=0. A write while full is dropped and pulses overflow the next cycle, even if a pop occurs in that same cycle. The head entry is read without popping; the pop happens only on frame completion.
- FSM states:
  - IDLE: ps2_clk=1, ps2_data=1. If FIFO is non-empty and inhibit=0, load the head into an 11-bit shift register, set bit index 0 and go to SETUP.
  - SETUP: ps2_clk=1, ps2_data=current bit, for CLK_DIV cycles, then go to LOW.
  - LOW: ps2_clk=0, ps2_data held, for CLK_DIV cycles. The receiver samples on this falling edge. After LOW of bit 10, pop the FIFO and go to GAP; otherwise bit index +1 and go to SETUP.
  - GAP: both lines high for GAP_CYCLES, then go to IDLE. IDLE re-evaluates on the next cycle.
- Latency:
  - wr_en sampled at edge E0 with FIFO empty and IDLE: busy=1 and ps2_data=0 after edge E1.
  - First ps2_clk fall after edge E1+CLK_DIV.
  - Frame occupies 22*CLK_DIV cycles plus GAP_CYCLES, plus 1 IDLE cycle before the next frame.
- Back-to-back bytes: IDLE lasts exactly 1 cycle between frames while the FIFO is non-empty.
- Inhibit:
  - In IDLE, inhibit=1 prevents a start.
  - In SETUP/LOW with bit index <=9, inhibit=1 aborts on the next edge: lines go high and the FSM goes to GAP without popping, so the same byte is resent in full once inhibit=0.
  - Inhibit during bit 10 (stop) or GAP is ignored; that frame counts as delivered.
- Outputs are registered; ps2_clk and ps2_data change only on clk rising edges. ps2_data never changes while ps2_clk=0.
- Counters wrap only via explicit reload. The FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; the count register is log2(FIFO_DEPTH)+1 bits.

Test Plan (CLK_DIV=4, GAP_CYCLES=8):
- Reset then idle 50 cycles -> ps2_clk=1, ps2_data=1, busy=0, full=0 throughout.
- Write 0x1C once -> ps2_data=0 after next edge; 11 ps2_clk falls with sampled bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0). busy lasts 96 cycles. A receiver model reports 0x1C.
- Write 0xF0 then 0x1C on consecutive cycles -> two frames, parity bits 1 then 0; second start bit exactly 97 cycles after the first. Receiver model reports F0,1C.
- Write 9 bytes on consecutive cycles while idle -> full=1 after 8 accepted, write 9 dropped and overflow pulses once. Exactly 8 frames sent; full deasserts after the first pop.
- Assert inhibit during bit 4 of 0xAA for 20 cycles -> lines high within 1 cycle, no further ps2_clk falls while inhibited. Then a complete 0xAA frame (parity 1) follows; FIFO count is unchanged until that frame ends.
- Assert clrn during bit 6 of a frame with 3 bytes queued -> ps2_clk=1 and ps2_data=1 immediately. After release, no frames are sent and busy=0.

Source files
------------

// File: rtl/ps2_kbd_tx_if.sv
// Write-side bus of the PS/2 keyboard-end frame transmitter.
// The producer (master) pushes scan-code bytes; the transmitter (slave)
// reports FIFO full and a one-cycle overflow pulse for dropped writes.
interface ps2_kbd_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       overflow;

  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output overflow
  );
endinterface

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side (keyboard-end) frame transmitter.
// Queued scan-code bytes are serialised as 11-bit PS/2 frames
// (start, d0..d7, odd parity, stop) on ps2_clk/ps2_data. A host inhibit
// before the stop bit aborts the frame and the same byte is resent later.
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         clrn,
  ps2_kbd_tx_if.slave  bus,
  input  logic         inhibit,
  output logic         busy,
  output logic         ps2_clk,
  output logic         ps2_data
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   COUNT_ZERO = (PTR_W + 1)'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    LOW   = 2'd2,
    GAP   = 2'd3
  } state_t;

  // PS/2 uses odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    odd_parity = ~^data;
  endfunction

  // Frame word, transmitted from bit 0 upward: start, d0..d7, parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] data);
    make_frame = {1'b1, odd_parity(data), data, 1'b0};
  endfunction

  // ---------------- write FIFO ----------------
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_nxt_s;
  logic             full_r;
  logic             overflow_r;
  logic             push_s;
  logic             pop_s;
  logic             empty_s;

  // Full is taken from the registered flag, so a write while full is
  // dropped even when the frame engine pops in the same cycle.
  assign push_s  = bus.wr_en & ~full_r;
  assign empty_s = (count_r == COUNT_ZERO);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + COUNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - COUNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // FIFO pointers, occupancy and the registered full/overflow flags.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= COUNT_ZERO;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == DEPTH_CNT);
      overflow_r <= bus.wr_en & full_r;
    end
  end

  assign bus.full     = full_r;
  assign bus.overflow = overflow_r;

  // ---------------- frame FSM ----------------
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [3:0]       bit_idx_r;
  logic [3:0]       bit_idx_nxt_s;
  logic [10:0]      shift_r;
  logic [10:0]      shift_nxt_s;
  logic             abort_s;
  logic             ps2_clk_nxt_s;
  logic             ps2_data_nxt_s;
  logic             busy_r;
  logic             ps2_clk_r;
  logic             ps2_data_r;

  // Inhibit only matters before the stop bit; once bit 10 is on the wire
  // the frame counts as delivered.
  assign abort_s = inhibit & (bit_idx_r <= 4'd9);

  // Next-state, divider and shift-register control.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    pop_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && !inhibit) begin
          state_nxt_s   = SETUP;
          shift_nxt_s   = make_frame(mem_r[rd_ptr_r]);
          bit_idx_nxt_s = 4'd0;
          cnt_nxt_s     = CNT_ZERO;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      SETUP: begin
        if (abort_s) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == DIV_LAST) begin
          state_nxt_s = LOW;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      LOW: begin
        if (abort_s) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == DIV_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          if (bit_idx_r == 4'd10) begin
            // Stop bit clocked out: the head byte is now delivered.
            pop_s       = 1'b1;
            state_nxt_s = GAP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 4'd1;
            shift_nxt_s   = {1'b1, shift_r[10:1]};
            state_nxt_s   = SETUP;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Line levels for the coming cycle, decoded from the next state so the
  // pins themselves can be flops.
  always_comb begin
    ps2_clk_nxt_s  = 1'b1;
    ps2_data_nxt_s = 1'b1;
    case (state_nxt_s)
      SETUP: begin
        ps2_clk_nxt_s  = 1'b1;
        ps2_data_nxt_s = shift_nxt_s[0];
      end
      LOW: begin
        ps2_clk_nxt_s  = 1'b0;
        ps2_data_nxt_s = shift_nxt_s[0];
      end
      IDLE, GAP: begin
        ps2_clk_nxt_s  = 1'b1;
        ps2_data_nxt_s = 1'b1;
      end
      default: begin
        ps2_clk_nxt_s  = 1'b1;
        ps2_data_nxt_s = 1'b1;
      end
    endcase
  end

  // FSM state, divider, shift register and registered line/busy outputs.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      bit_idx_r  <= 4'd0;
      shift_r    <= 11'h7FF;
      busy_r     <= 1'b0;
      ps2_clk_r  <= 1'b1;
      ps2_data_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      shift_r    <= shift_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
      ps2_clk_r  <= ps2_clk_nxt_s;
      ps2_data_r <= ps2_data_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign ps2_clk  = ps2_clk_r;
  assign ps2_data = ps2_data_r;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: a table of bytes with hand-computed frame words
// plus directed sequences for back-to-back, overflow, inhibit and reset.
module tb_ps2_kbd_tx;
  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int FIFO_DEPTH = 8;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;   // bit 0 = start bit ... bit 10 = stop bit
  } vec_t;

  logic clk     = 1'b0;
  logic clrn    = 1'b1;
  logic inhibit = 1'b0;
  logic busy;
  logic ps2_clk;
  logic ps2_data;

  ps2_kbd_tx_if bus();

  ps2_kbd_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .bus      (bus),
    .inhibit  (inhibit),
    .busy     (busy),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // receiver model and line monitor
  int          cyc = 0;
  int          fall_cnt = 0;
  int          rx_bits = 0;
  logic [10:0] rx_shift = 11'h000;
  logic [10:0] rx_words [$];
  int          start_cyc [$];
  int          high_run = 0;
  int          low_data_changes = 0;
  int          ovf_cnt = 0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;

  // Sample the lines on the falling system-clock edge like a PS/2 receiver.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_clk && !ps2_clk) begin
      fall_cnt = fall_cnt + 1;
      rx_shift = {ps2_data, rx_shift[10:1]};
      rx_bits  = rx_bits + 1;
      if (rx_bits == 11) begin
        rx_words.push_back(rx_shift);
        rx_bits = 0;
      end
    end
    if (!prev_clk && !ps2_clk && (ps2_data != prev_data)) low_data_changes++;
    if (prev_clk && prev_data && ps2_clk && !ps2_data) start_cyc.push_back(cyc);
    if (ps2_clk) high_run++;
    else high_run = 0;
    if (high_run > 3 * CLK_DIV) rx_bits = 0;
    if (bus.overflow) ovf_cnt++;
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Write one byte, then stop one edge after the write edge (E1).
  task automatic push_one(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en = 1'b0;
    tick();
  endtask

  task automatic wait_falls(input int target, input int bound);
    int n;
    n = 0;
    while (fall_cnt < target && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_words(input int target, input int bound);
    int n;
    n = 0;
    while (rx_words.size() < target && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [10:0] last_word();
    if (rx_words.size() == 0) return 11'h000;
    return rx_words[rx_words.size() - 1];
  endfunction

  initial begin
    vec_t vecs [8];
    int   n, first_low, base_f, base_w, s0, f, bad, ovf0;

    vecs[0] = '{8'h1C, 11'h438};
    vecs[1] = '{8'hF0, 11'h7E0};
    vecs[2] = '{8'hAA, 11'h754};
    vecs[3] = '{8'h00, 11'h600};
    vecs[4] = '{8'hFF, 11'h7FE};
    vecs[5] = '{8'h01, 11'h402};
    vecs[6] = '{8'h80, 11'h500};
    vecs[7] = '{8'h5A, 11'h6B4};

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) tick();
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    check("rst_busy", busy, 0);
    check("rst_full", bus.full, 0);
    check("rst_overflow", bus.overflow, 0);
    clrn = 1'b0;

    bad = 0;
    repeat (50) begin
      tick();
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0 || bus.full !== 1'b0) bad++;
    end
    check("idle_50", bad, 0);

    // single frames from the table
    for (int i = 0; i < 8; i++) begin
      base_f = fall_cnt;
      base_w = rx_words.size();
      push_one(vecs[i].data);
      check("start_data", ps2_data, 0);
      check("start_busy", busy, 1);
      n = 0;
      first_low = -1;
      while (busy && n < 200) begin
        if (!ps2_clk && first_low < 0) first_low = n;
        n++;
        tick();
      end
      check("first_fall", first_low, CLK_DIV);
      check("busy_len", n, 96);
      check("falls", fall_cnt - base_f, 11);
      check("rx_frames", rx_words.size() - base_w, 1);
      check("rx_word", last_word(), vecs[i].frame);
    end

    // back-to-back F0, 1C
    tick();
    base_w = rx_words.size();
    s0 = start_cyc.size();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hF0;
    tick();
    bus.wr_data = 8'h1C;
    tick();
    bus.wr_en = 1'b0;
    wait_words(base_w + 2, 400);
    wait_idle(200);
    check("b2b_frames", rx_words.size() - base_w, 2);
    check("b2b_word0", (rx_words.size() >= base_w + 2) ? rx_words[base_w] : 11'h0, 11'h7E0);
    check("b2b_word1", (rx_words.size() >= base_w + 2) ? rx_words[base_w + 1] : 11'h0, 11'h438);
    check("b2b_start_gap",
          (start_cyc.size() >= s0 + 2) ? start_cyc[s0 + 1] - start_cyc[s0] : -1, 97);

    // nine writes into an eight-entry FIFO
    tick();
    base_f = fall_cnt;
    base_w = rx_words.size();
    ovf0 = ovf_cnt;
    for (int k = 0; k < 9; k++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = (k < 8) ? vecs[k].data : 8'h33;
      if (k == 7) check("full_at_7", bus.full, 0);
      if (k == 8) check("full_at_8", bus.full, 1);
      tick();
    end
    bus.wr_en = 1'b0;
    check("overflow_pulse", bus.overflow, 1);
    tick();
    check("overflow_end", bus.overflow, 0);
    wait_falls(base_f + 11, 200);
    check("full_before_pop", bus.full, 1);
    repeat (4) tick();
    check("full_after_pop", bus.full, 0);
    wait_words(base_w + 8, 8 * 97 + 100);
    wait_idle(200);
    repeat (150) tick();
    check("fill_frames", rx_words.size() - base_w, 8);
    for (int k = 0; k < 8; k++) begin
      check("fill_word", (rx_words.size() > base_w + k) ? rx_words[base_w + k] : 11'h0,
            vecs[k].frame);
    end
    check("overflow_count", ovf_cnt - ovf0, 1);

    // inhibit during bit 4 of 0xAA
    base_f = fall_cnt;
    base_w = rx_words.size();
    push_one(8'hAA);
    wait_falls(base_f + 5, 100);
    check("inh_reach_bit4", fall_cnt - base_f, 5);
    inhibit = 1'b1;
    tick();
    check("inh_clk_high", ps2_clk, 1);
    check("inh_data_high", ps2_data, 1);
    f = fall_cnt;
    repeat (19) tick();
    check("inh_no_falls", fall_cnt - f, 0);
    check("inh_busy", busy, 0);
    check("inh_no_frame", rx_words.size() - base_w, 0);
    inhibit = 1'b0;
    wait_words(base_w + 1, 200);
    wait_idle(200);
    check("inh_resent", rx_words.size() - base_w, 1);
    check("inh_word", last_word(), 11'h754);
    check("inh_total_falls", fall_cnt - base_f, 16);

    // inhibit while idle holds off the start
    tick();
    base_f = fall_cnt;
    base_w = rx_words.size();
    inhibit = 1'b1;
    push_one(8'h5A);
    repeat (30) tick();
    check("idle_inh_busy", busy, 0);
    check("idle_inh_falls", fall_cnt - base_f, 0);
    inhibit = 1'b0;
    wait_words(base_w + 1, 200);
    wait_idle(200);
    check("idle_inh_word", last_word(), 11'h6B4);

    // inhibit during the stop bit is ignored
    tick();
    base_f = fall_cnt;
    base_w = rx_words.size();
    push_one(8'h01);
    wait_falls(base_f + 11, 200);
    inhibit = 1'b1;
    wait_idle(200);
    check("stop_inh_frame", rx_words.size() - base_w, 1);
    check("stop_inh_word", last_word(), 11'h402);
    repeat (30) tick();
    inhibit = 1'b0;
    repeat (120) tick();
    check("stop_inh_no_resend", fall_cnt - base_f, 11);
    check("stop_inh_busy", busy, 0);

    // reset during bit 6 with three bytes queued
    base_f = fall_cnt;
    base_w = rx_words.size();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h1C;
    tick();
    bus.wr_data = 8'hF0;
    tick();
    bus.wr_data = 8'hAA;
    tick();
    bus.wr_en = 1'b0;
    wait_falls(base_f + 7, 200);
    check("rst_reach_bit6", fall_cnt - base_f, 7);
    clrn = 1'b1;
    #1;
    check("midrst_clk", ps2_clk, 1);
    check("midrst_data", ps2_data, 1);
    check("midrst_busy", busy, 0);
    tick();
    clrn = 1'b0;
    bad = 0;
    repeat (200) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    check("postrst_idle", bad, 0);
    check("postrst_falls", fall_cnt - base_f, 7);
    check("postrst_frames", rx_words.size() - base_w, 0);

    check("data_stable_low", low_data_changes, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
